// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: registered RGB565 test-pattern source for a 480x272 LCD.
// Takes syncs and active coordinates from the timing generator and drives the
// panel with one of eight patterns. Every output lags its inputs by exactly
// two clocks. Pattern and box changes happen only on the frame tick.
// Optional build macro PATTERN_BORDER_EN adds a 1-px white frame around the
// active area on top of any pattern.
`timescale 1ns/1ps

module lcd_pattern_gen #(
  parameter int H_ACTIVE           = 480,
  parameter int V_ACTIVE           = 272,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BOX_SIZE           = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_hs,
  input  logic       in_vs,
  input  logic       in_de,
  input  logic [9:0] active_x,
  input  logic [9:0] active_y,
  input  logic [2:0] pattern_sel,
  input  logic       auto_cycle,
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic [2:0] cur_pattern
);

  localparam int BAR16_W = H_ACTIVE / 16;
  localparam int BAR8_W  = H_ACTIVE / 8;
  localparam int CNT_W   = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [9:0]       BOX_X_MAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]       BOX_Y_MAX = 10'(V_ACTIVE - BOX_SIZE);

  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

  // stage 1: registered copies of the timing-generator inputs
  logic       r_hs_p1, r_vs_p1, r_de_p1;
  logic [9:0] r_x_p1, r_y_p1;
  // previous stage-1 vsync, for rising-edge detection
  logic       r_vs_d;
  // stage 2: output registers
  logic       r_hs_p2, r_vs_p2, r_de_p2;
  logic [15:0] r_rgb_p2;

  // frame-synchronous state
  logic [2:0]       r_cur_pattern;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [9:0]       r_box_x, r_box_y;
  logic             r_box_dx_neg, r_box_dy_neg;

  logic        w_tick;
  logic [31:0] w_x32;
  logic [15:0] w_bar16;
  logic [3:0]  w_bar8_idx;
  logic [15:0] w_bar8;
  logic [5:0]  w_ramp;
  logic        w_in_box;
  logic [15:0] w_pattern;
  logic [15:0] w_rgb_p1;

  assign w_tick = r_vs_p1 & ~r_vs_d;
  assign w_x32  = {22'd0, r_x_p1};
  assign w_ramp = r_x_p1[8:3];

  // ---- stage 0 -> stage 1 boundary ----
  // Stage 1: capture syncs and coordinates; remember last vsync for the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_p1 <= 1'b0;
      r_vs_p1 <= 1'b0;
      r_de_p1 <= 1'b0;
      r_x_p1  <= '0;
      r_y_p1  <= '0;
      r_vs_d  <= 1'b0;
    end else begin
      r_hs_p1 <= in_hs;
      r_vs_p1 <= in_vs;
      r_de_p1 <= in_de;
      r_x_p1  <= active_x;
      r_y_p1  <= active_y;
      r_vs_d  <= r_vs_p1;
    end
  end

  // Pattern selection: manual load or auto-advance, only on the frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_pattern <= 3'd0;
      r_frame_cnt   <= '0;
    end else if (!auto_cycle) begin
      r_frame_cnt <= '0;
      if (w_tick) r_cur_pattern <= pattern_sel;
    end else if (w_tick) begin
      if (r_frame_cnt == CNT_LAST) begin
        r_frame_cnt   <= '0;
        r_cur_pattern <= (r_cur_pattern >= 3'd6) ? 3'd0 : r_cur_pattern + 3'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  // Bouncing box: one step per tick on each axis, reversing at the walls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_box_x      <= '0;
      r_box_y      <= '0;
      r_box_dx_neg <= 1'b0;
      r_box_dy_neg <= 1'b0;
    end else if (w_tick) begin
      if (!r_box_dx_neg) begin
        if (r_box_x == BOX_X_MAX) begin
          r_box_dx_neg <= 1'b1;
          r_box_x      <= r_box_x - 10'd1;
        end else begin
          r_box_x <= r_box_x + 10'd1;
        end
      end else begin
        if (r_box_x == 10'd0) begin
          r_box_dx_neg <= 1'b0;
          r_box_x      <= r_box_x + 10'd1;
        end else begin
          r_box_x <= r_box_x - 10'd1;
        end
      end
      if (!r_box_dy_neg) begin
        if (r_box_y == BOX_Y_MAX) begin
          r_box_dy_neg <= 1'b1;
          r_box_y      <= r_box_y - 10'd1;
        end else begin
          r_box_y <= r_box_y + 10'd1;
        end
      end else begin
        if (r_box_y == 10'd0) begin
          r_box_dy_neg <= 1'b0;
          r_box_y      <= r_box_y + 10'd1;
        end else begin
          r_box_y <= r_box_y - 10'd1;
        end
      end
    end
  end

  // Single-bit bars: bar k lights bit 15-k; columns past the last bar stay dark.
  always_comb begin
    w_bar16 = '0;
    for (int k = 0; k < 16; k++) begin
      if (w_x32 >= 32'(k * BAR16_W) && w_x32 < 32'((k + 1) * BAR16_W))
        w_bar16 = 16'h8000 >> k;
    end
  end

  // Colour bars: locate the bar index, then map it to the classic colour order.
  always_comb begin
    w_bar8_idx = 4'd8;
    for (int k = 0; k < 8; k++) begin
      if (w_x32 >= 32'(k * BAR8_W) && w_x32 < 32'((k + 1) * BAR8_W))
        w_bar8_idx = 4'(k);
    end
    case (w_bar8_idx)
      4'd0:    w_bar8 = 16'hFFFF;  // white
      4'd1:    w_bar8 = 16'hFFE0;  // yellow
      4'd2:    w_bar8 = 16'h07FF;  // cyan
      4'd3:    w_bar8 = 16'h07E0;  // green
      4'd4:    w_bar8 = 16'hF81F;  // magenta
      4'd5:    w_bar8 = 16'hF800;  // red
      4'd6:    w_bar8 = 16'h001F;  // blue
      default: w_bar8 = 16'h0000;  // black
    endcase
  end

  assign w_in_box = ({1'b0, r_x_p1} >= {1'b0, r_box_x}) &&
                    ({1'b0, r_x_p1} <  {1'b0, r_box_x} + 11'(BOX_SIZE)) &&
                    ({1'b0, r_y_p1} >= {1'b0, r_box_y}) &&
                    ({1'b0, r_y_p1} <  {1'b0, r_box_y} + 11'(BOX_SIZE));

  // Stage-1 colour: pick the active pattern, blank outside de, optional border.
  always_comb begin
    case (r_cur_pattern)
      3'd0:    w_pattern = w_bar16;
      3'd1:    w_pattern = w_bar8;
      3'd2:    w_pattern = {w_ramp[5:1], w_ramp, w_ramp[5:1]};
      3'd3:    w_pattern = (r_x_p1[4] ^ r_y_p1[4]) ? RGB_WHITE : RGB_BLACK;
      3'd4:    w_pattern = w_in_box ? RGB_WHITE : RGB_BLUE;
      3'd5:    w_pattern = RGB_WHITE;
      default: w_pattern = RGB_BLACK;
    endcase
    w_rgb_p1 = r_de_p1 ? w_pattern : RGB_BLACK;
`ifdef PATTERN_BORDER_EN
    if (r_de_p1 && (r_x_p1 == 10'd0 || r_x_p1 == 10'(H_ACTIVE - 1) ||
                    r_y_p1 == 10'd0 || r_y_p1 == 10'(V_ACTIVE - 1)))
      w_rgb_p1 = RGB_WHITE;
`endif
  end

  // ---- stage 1 -> stage 2 boundary ----
  // Stage 2: register syncs and colour together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_p2  <= 1'b0;
      r_vs_p2  <= 1'b0;
      r_de_p2  <= 1'b0;
      r_rgb_p2 <= '0;
    end else begin
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_de_p2  <= r_de_p1;
      r_rgb_p2 <= w_rgb_p1;
    end
  end

  assign out_hs      = r_hs_p2;
  assign out_vs      = r_vs_p2;
  assign out_de      = r_de_p2;
  assign lcd_r       = r_rgb_p2[15:11];
  assign lcd_g       = r_rgb_p2[10:5];
  assign lcd_b       = r_rgb_p2[4:0];
  assign cur_pattern = r_cur_pattern;

endmodule

// File: doc/lcd_pattern_gen.md
Name: lcd_pattern_gen

Overview:
- Registered test-pattern source for the 480-wide RGB565 LCD path.
- Sits directly downstream of the VGA/LCD timing generator. Consumes its hs/vs/de and active_x/active_y, and drives the LCD pins with patterns aligned to those syncs.
- Replaces the fixed combinational bar logic in board bring-up tops.
- Adds selectable patterns, frame-synchronous switching, auto-cycling and a bouncing box for motion checks.

Parameters:
- H_ACTIVE, 480, active pixels per line.
- V_ACTIVE, 272, active lines per frame.
- FRAMES_PER_PATTERN, 120, frame ticks per pattern in auto-cycle mode (>=1).
- BOX_SIZE, 32, side length of the moving box in pixels (< V_ACTIVE).

Ports:
- clk  in  1  pixel clock (lcd_dclk domain).
- rst_n  in  1  asynchronous active-low reset.
- in_hs  in  1  hsync from timing generator.
- in_vs  in  1  vsync from timing generator, active high.
- in_de  in  1  data enable from timing generator.
- active_x  in  10  pixel column, valid when in_de=1.
- active_y  in  10  pixel row, valid when in_de=1.
- pattern_sel  in  3  manual pattern select.
- auto_cycle  in  1  1 = cycle patterns automatically.
- out_hs  out  1  in_hs delayed 2 clk.
- out_vs  out  1  in_vs delayed 2 clk.
- out_de  out  1  in_de delayed 2 clk.
- lcd_r  out  5  red.
- lcd_g  out  6  green.
- lcd_b  out  5  blue.
- cur_pattern  out  3  pattern currently displayed.

Behaviour:
- Reset: all outputs 0, cur_pattern=0, box_x=box_y=0, box directions +x/+y, frame counter 0, vs edge register 0.
- Latency: fixed 2 clk from inputs to every output. hs/vs/de pass through a 2-stage shift register. Colour is computed in stage 1 and registered in stage 2.
- Blanking: RGB is 0 whenever stage-1 de=0.
- Frame tick: single-cycle pulse when registered in_vs goes 0->1. The pattern and box state update only on the tick, so there is no mid-frame tearing.
- Manual mode (auto_cycle=0): on a tick, cur_pattern<=pattern_sel. The frame counter is held at 0.
- Auto mode (auto_cycle=1): each tick increments the frame counter. When it reaches FRAMES_PER_PATTERN-1 on a tick:
  - the counter clears;
  - cur_pattern advances 0->1->...->6->0 (7 is skipped).
  - Entering auto mode continues from the current cur_pattern.
- Patterns (x=active_x, y=active_y, RGB given as r/g/b):
  - 0: 16 single-bit bars, each H_ACTIVE/16 wide. Bar k lights bit (15-k) of {r,g,b}, so bar 0 = r[4], bar 15 = b[0].
  - 1: 8 colour bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black. Full-scale components are 31/63/31.
  - 2: gray ramp. ramp = x[8:3] (6 bits, wraps). g=ramp, r=b=ramp[5:1].
  - 3: 16x16 checkerboard. x[4]^y[4] = 1 gives white, else black.
  - 4: moving box. White where box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE; blue (b=31) elsewhere.
  - 5: solid white.
  - 6: solid black.
  - 7: solid black (reserved).
- Box motion: on every tick, regardless of pattern, each axis steps 1 px in its direction.
  - If box_x==H_ACTIVE-BOX_SIZE while moving +, the x direction flips and box_x decrements the same tick. box_x==0 while moving - flips to +.
  - The y axis behaves the same with V_ACTIVE.
  - box_x ranges 0..H_ACTIVE-BOX_SIZE; box_y ranges 0..V_ACTIVE-BOX_SIZE.
- Coordinates >= H_ACTIVE/V_ACTIVE with de=1: colour is computed from the pattern formula unclipped. The timing generator never produces these.
- Reset mid-frame: outputs drop to 0 immediately. The first tick after release loads the pattern.
- Tick coincident with an auto_cycle change: the new mode applies on that tick.

Optional Feature:
- Macro PATTERN_BORDER_EN.
- Defined: a 1-px white border overrides any pattern when x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 (de=1).
- Undefined: no border logic; the pattern covers the full active area.

Test Plan:
- Reset release, manual sel=1, one frame, sample x=0 and x=420 on y=10 -> first valid output is the pattern from the next tick; RGB 31/63/31 and 0/0/0; RGB is 0 and syncs delayed exactly 2 clk during blanking.
- Manual sel=0, x=0/30/450 -> {r,g,b}=16'h8000/16'h4000/16'h0001.
- pattern_sel 3->2 changed mid-frame -> remainder of frame still checkerboard; next frame shows ramp; x=64 gives g=8, r=b=4.
- auto_cycle=1, FRAMES_PER_PATTERN=2 -> cur_pattern 0,0,1,1,...,6,6,0 across 14 ticks; 7 never appears.
- Pattern 4 for 450 ticks, BOX_SIZE=32 -> box_x reaches 448 at tick 448, box_x=447 at tick 449 (direction flipped); box_y bounces at 240; pixel at (box_x,box_y) is white, (box_x+32,box_y) is blue.
- PATTERN_BORDER_EN defined, pattern 6 -> (0,100), (479,5), (7,271) white; (1,1) black.
